// File: rtl/name_entry_ctrl.sv
// Scoreboard name-entry writer: edits three letter codes with edge-detected and
// auto-repeating buttons, and pulses name_done when the name is committed.
module name_entry_ctrl #(
    parameter int unsigned CHAR_W       = 5,
    parameter int unsigned NUM_CHARS    = 26,
    parameter int unsigned REPEAT_DELAY = 25_000_000,
    parameter int unsigned REPEAT_RATE  = 10_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic                  btn_left,
    input  logic                  btn_right,
    input  logic                  btn_confirm,
    output logic [3*CHAR_W-1:0]   player_name,
    output logic [1:0]            input_pos,
    output logic                  editing,
    output logic                  name_done
);

    localparam int unsigned CNT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [CHAR_W-1:0] CHAR_MAX  = CHAR_W'(NUM_CHARS - 1);

    typedef enum logic [1:0] {StIdle, StEdit, StCommit} state_e;

    state_e              state_q, state_d;
    logic [3*CHAR_W-1:0] name_q, name_d;
    logic [1:0]          pos_q, pos_d;
    logic                editing_q, editing_d;
    logic                done_q, done_d;
    logic [4:0]          prev_q;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [4:0]          btn_vec, press;
    logic                run, rpt_step, step_up, step_down;
    logic [CHAR_W-1:0]   cur_char, new_char;

    always_comb begin
        btn_vec = {btn_up, btn_down, btn_left, btn_right, btn_confirm};
        press   = btn_vec & ~prev_q;

        // Auto-repeat only while a single up/down button is the sole button held.
        run = (state_q == StEdit) && (pos_q != 2'd3) && (btn_up ^ btn_down) &&
              !(btn_left | btn_right | btn_confirm);
        rpt_step  = run && (press == 5'b0) && (cnt_q == CNT_LAST);
        step_up   = press[4] | (rpt_step & btn_up);
        step_down = press[3] | (rpt_step & btn_down);

        case (pos_q)
            2'd0:    cur_char = name_q[3*CHAR_W-1 -: CHAR_W];
            2'd1:    cur_char = name_q[2*CHAR_W-1 -: CHAR_W];
            2'd2:    cur_char = name_q[CHAR_W-1:0];
            default: cur_char = '0;
        endcase

        if (step_up) begin
            new_char = (cur_char == CHAR_MAX) ? '0 : cur_char + 1'b1;
        end else begin
            new_char = (cur_char == '0) ? CHAR_MAX : cur_char - 1'b1;
        end

        if (!run || (press != 5'b0) || start || abort) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = CNT_RELOAD;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        state_d   = state_q;
        name_d    = name_q;
        pos_d     = pos_q;
        editing_d = editing_q;
        done_d    = 1'b0;

        case (state_q)
            StIdle: begin
                editing_d = 1'b0;
                if (start) begin
                    state_d   = StEdit;
                    name_d    = '0;
                    pos_d     = 2'd0;
                    editing_d = 1'b1;
                end
            end
            StEdit: begin
                if (abort) begin
                    state_d   = StIdle;
                    editing_d = 1'b0;
                end else if (start) begin
                    name_d = '0;
                    pos_d  = 2'd0;
                end else if (press[0]) begin
                    if (pos_q == 2'd3) begin
                        state_d   = StCommit;
                        editing_d = 1'b0;
                        done_d    = 1'b1;
                    end else begin
                        pos_d = pos_q + 2'd1;
                    end
                end else if (press[2] ^ press[1]) begin
                    pos_d = press[2] ? pos_q - 2'd1 : pos_q + 2'd1;
                end else if ((step_up ^ step_down) && (pos_q != 2'd3)) begin
                    case (pos_q)
                        2'd0:    name_d[3*CHAR_W-1 -: CHAR_W] = new_char;
                        2'd1:    name_d[2*CHAR_W-1 -: CHAR_W] = new_char;
                        default: name_d[CHAR_W-1:0]           = new_char;
                    endcase
                end
            end
            StCommit: begin
                state_d   = StIdle;
                editing_d = 1'b0;
            end
            default: begin
                state_d   = StIdle;
                editing_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            name_q    <= '0;
            pos_q     <= 2'd0;
            editing_q <= 1'b0;
            done_q    <= 1'b0;
            prev_q    <= 5'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            name_q    <= name_d;
            pos_q     <= pos_d;
            editing_q <= editing_d;
            done_q    <= done_d;
            prev_q    <= btn_vec;
            cnt_q     <= cnt_d;
        end
    end

    assign player_name = name_q;
    assign input_pos   = pos_q;
    assign editing     = editing_q;
    assign name_done   = done_q;

endmodule

// File: tb/tb_name_entry_ctrl.sv
// Directed bench for name_entry_ctrl with shortened auto-repeat timing.
module tb_name_entry_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort;
    logic        btn_up, btn_down, btn_left, btn_right, btn_confirm;
    logic [14:0] player_name;
    logic [1:0]  input_pos;
    logic        editing, name_done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_ch0;

    name_entry_ctrl #(
        .CHAR_W      (5),
        .NUM_CHARS   (26),
        .REPEAT_DELAY(8),
        .REPEAT_RATE (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .btn_right  (btn_right),
        .btn_confirm(btn_confirm),
        .player_name(player_name),
        .input_pos  (input_pos),
        .editing    (editing),
        .name_done  (name_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press_up();      btn_up = 1;      tick(); btn_up = 0;      tick(); endtask
    task automatic press_down();    btn_down = 1;    tick(); btn_down = 0;    tick(); endtask
    task automatic press_left();    btn_left = 1;    tick(); btn_left = 0;    tick(); endtask
    task automatic press_right();   btn_right = 1;   tick(); btn_right = 0;   tick(); endtask
    task automatic press_confirm(); btn_confirm = 1; tick(); btn_confirm = 0; tick(); endtask

    initial begin
        rst_n = 0; start = 0; abort = 0;
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0; btn_confirm = 0;
        #12;
        check("rst_name", player_name, 32'h0);
        check("rst_pos", input_pos, 0);
        check("rst_editing", editing, 0);
        check("rst_done", name_done, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        start = 1; tick(); start = 0;
        check("start_editing", editing, 1);
        check("start_name", player_name, 32'h0);
        check("start_pos", input_pos, 0);

        press_down();
        check("down_wrap", player_name, 32'h6400);
        press_right();
        press_up();
        press_up();
        press_right();
        press_right();
        check("pos3", input_pos, 3);
        check("name_6440", player_name, 32'h6440);

        btn_confirm = 1; tick(); btn_confirm = 0;
        check("commit_done", name_done, 1);
        check("commit_editing", editing, 0);
        tick();
        check("done_one_cycle", name_done, 0);
        check("idle_editing", editing, 0);
        check("commit_name_held", player_name, 32'h6440);
        press_up();
        check("idle_ignores_up", player_name, 32'h6440);

        start = 1; tick(); start = 0;
        check("restart_name", player_name, 32'h0);
        press_left();
        check("left_wrap", input_pos, 3);
        press_up();
        check("up_at_pos3", player_name, 32'h0);
        press_right();
        check("right_wrap", input_pos, 0);
        press_right();
        press_confirm();
        check("confirm_advance", input_pos, 2);
        check("confirm_no_done", name_done, 0);
        press_left();
        press_left();
        check("back_to_0", input_pos, 0);

        // Held up: edge step, then steps 8, 12, 16, 20 cycles later.
        btn_up = 1; tick();
        check("hold_edge", player_name[14:10], 1);
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_ch0 = 1 + int'(k >= 8) + int'(k >= 12) + int'(k >= 16) + int'(k >= 20);
            check($sformatf("hold_k%0d", k), player_name[14:10], exp_ch0);
        end
        btn_up = 0; tick();
        check("hold_release", player_name, 32'h1400);

        press_right();
        btn_left = 1; tick();
        check("left_held_pos", input_pos, 0);
        btn_up = 1; tick();
        check("up_with_left_edge", player_name[14:10], 6);
        repeat (20) tick();
        check("up_with_left_no_rpt", player_name[14:10], 6);
        btn_up = 0; btn_left = 0; tick();

        btn_up = 1; btn_down = 1; tick(); btn_up = 0; btn_down = 0; tick();
        check("up_down_same", player_name, 32'h1800);
        btn_left = 1; btn_right = 1; tick(); btn_left = 0; btn_right = 0; tick();
        check("left_right_same", input_pos, 0);

        press_right();
        press_right();
        press_up();
        check("pos2_up", player_name, 32'h1801);
        abort = 1; tick();
        check("abort_editing", editing, 0);
        check("abort_done", name_done, 0);
        check("abort_name", player_name, 32'h1801);
        check("abort_pos", input_pos, 2);
        abort = 0; tick();
        check("abort_no_done_later", name_done, 0);
        press_up();
        check("abort_idle_ignores", player_name, 32'h1801);

        start = 1; tick(); start = 0;
        press_up();
        abort = 1; start = 1; tick(); abort = 0; start = 0;
        check("abort_beats_start_ed", editing, 0);
        check("abort_beats_start_nm", player_name, 32'h0400);
        tick();

        start = 1; tick(); start = 0;
        press_up();
        press_right();
        @(posedge clk); #2;
        rst_n = 0; #1;
        check("async_rst_name", player_name, 32'h0);
        check("async_rst_pos", input_pos, 0);
        check("async_rst_editing", editing, 0);
        check("async_rst_done", name_done, 0);
        @(negedge clk);
        rst_n = 1;
        tick();
        check("post_rst_idle", editing, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
